// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR bank controller.
package ddr_pkg;

    typedef enum logic [2:0] {
        CmdNop = 3'd0,
        CmdAct = 3'd1,
        CmdRd  = 3'd2,
        CmdWr  = 3'd3,
        CmdPre = 3'd4
    } cmd_t;

    typedef enum logic [2:0] {
        StClosed,
        StActivating,
        StActive,
        StReading,
        StWriting,
        StPrecharging
    } bank_state_t;

    // Column of a given beat: the low log2(bl) bits wrap inside the aligned burst,
    // and the high bits never see a carry.
    function automatic int unsigned burst_col(input int unsigned base,
                                              input int unsigned beat,
                                              input int unsigned bl);
        return (base & ~(bl - 1)) | ((base + beat) & (bl - 1));
    endfunction

endpackage

// File: rtl/bank_array.sv
// Bank storage: one synchronous write port and one read port with a registered output.
module bank_array #(
    parameter int unsigned DEVICE_WIDTH = 4,
    parameter int unsigned DEPTH        = 32768,
    parameter int unsigned ADDR_W       = 15
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DEVICE_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [DEVICE_WIDTH-1:0] rdata
);

    logic [DEVICE_WIDTH-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ddr_bank_ctrl.sv
// Single DRAM bank: ACT/RD/WR/PRE command FSM, open-row register, timing counters and
// BL-beat bursts with sequential column wrap.
module ddr_bank_ctrl
    import ddr_pkg::*;
#(
    parameter int unsigned DEVICE_WIDTH = 4,
    parameter int unsigned ROWS         = 256,
    parameter int unsigned COLS         = 128,
    parameter int unsigned BL           = 8,
    parameter int unsigned tRCD         = 2,
    parameter int unsigned tRP          = 2,
    parameter int unsigned CL           = 3,
    parameter int unsigned CWL          = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  cmd_t                      cmd,
    input  logic [$clog2(ROWS)-1:0]   row,
    input  logic [$clog2(COLS)-1:0]   column,
    input  logic [DEVICE_WIDTH-1:0]   dqin,
    output logic [DEVICE_WIDTH-1:0]   dqout,
    output logic                      dq_valid,
    output logic                      row_open,
    output logic [$clog2(ROWS)-1:0]   open_row,
    output logic                      err
);

    localparam int unsigned RowW   = $clog2(ROWS);
    localparam int unsigned ColW   = $clog2(COLS);
    localparam int unsigned AddrW  = RowW + ColW;
    localparam int unsigned RdEnd  = CL + BL;
    localparam int unsigned WrEnd  = CWL + BL;
    localparam int unsigned MaxA   = (tRCD > tRP) ? tRCD : tRP;
    localparam int unsigned MaxB   = (RdEnd > WrEnd) ? RdEnd : WrEnd;
    localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    // cnt_q holds cycles elapsed since the command was accepted.
    localparam logic [CntW-1:0] LimRcd  = CntW'(tRCD);
    localparam logic [CntW-1:0] LimRp   = CntW'(tRP);
    localparam logic [CntW-1:0] LimRd   = CntW'(RdEnd);
    localparam logic [CntW-1:0] LimWr   = CntW'(WrEnd);
    localparam logic [CntW-1:0] RdFirst = CntW'(CL - 1);
    localparam logic [CntW-1:0] RdLast  = CntW'(CL + BL - 2);
    localparam logic [CntW-1:0] WrFirst = CntW'(CWL);
    localparam logic [CntW-1:0] WrLast  = CntW'(CWL + BL - 1);

    bank_state_t       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [RowW-1:0]   open_row_q, open_row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic              err_q, err_d;
    logic              dq_valid_q;
    logic              accept;
    logic              rd_issue, wr_en;
    logic [ColW-1:0]   rd_col, wr_col;
    logic [DEVICE_WIDTH-1:0] rdata;

    assign cmd_ready = (state_q == StClosed) || (state_q == StActive);
    assign accept    = cmd_valid && cmd_ready;
    assign cnt_inc   = cnt_q + 1'b1;

    // Next-state, counter and open-row logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        open_row_d = open_row_q;
        col_d      = col_q;
        err_d      = 1'b0;
        unique case (state_q)
            StClosed: begin
                if (accept) begin
                    case (cmd)
                        CmdAct: begin
                            open_row_d = row;
                            if (tRCD == 1) begin
                                state_d = StActive;
                            end else begin
                                state_d = StActivating;
                                cnt_d   = CntW'(1);
                            end
                        end
                        CmdRd, CmdWr, CmdPre: err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StActive: begin
                if (accept) begin
                    case (cmd)
                        CmdRd: begin
                            state_d = StReading;
                            col_d   = column;
                            cnt_d   = CntW'(1);
                        end
                        CmdWr: begin
                            state_d = StWriting;
                            col_d   = column;
                            cnt_d   = CntW'(1);
                        end
                        CmdPre: begin
                            if (tRP == 1) begin
                                state_d = StClosed;
                            end else begin
                                state_d = StPrecharging;
                                cnt_d   = CntW'(1);
                            end
                        end
                        CmdAct: err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StActivating, StReading, StWriting, StPrecharging: begin
                cnt_d = cnt_inc;
                if ((state_q == StActivating && cnt_inc == LimRcd) ||
                    (state_q == StReading    && cnt_inc == LimRd)  ||
                    (state_q == StWriting    && cnt_inc == LimWr)) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end else if (state_q == StPrecharging && cnt_inc == LimRp) begin
                    state_d = StClosed;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClosed;
        endcase
    end

    // Burst beat addressing: read address leads its data beat by one cycle.
    always_comb begin
        rd_issue = (state_q == StReading) && (cnt_q >= RdFirst) && (cnt_q <= RdLast);
        wr_en    = (state_q == StWriting) && (cnt_q >= WrFirst) && (cnt_q <= WrLast);
        rd_col   = ColW'(burst_col(32'(col_q), 32'(cnt_q - RdFirst), BL));
        wr_col   = ColW'(burst_col(32'(col_q), 32'(cnt_q - WrFirst), BL));
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClosed;
            cnt_q      <= '0;
            open_row_q <= '0;
            col_q      <= '0;
            err_q      <= 1'b0;
            dq_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            open_row_q <= open_row_d;
            col_q      <= col_d;
            err_q      <= err_d;
            dq_valid_q <= rd_issue;
        end
    end

    bank_array #(
        .DEVICE_WIDTH (DEVICE_WIDTH),
        .DEPTH        (ROWS * COLS),
        .ADDR_W       (AddrW)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({open_row_q, wr_col}),
        .wdata (dqin),
        .raddr ({open_row_q, rd_col}),
        .rdata (rdata)
    );

    assign dq_valid = dq_valid_q;
    assign dqout    = dq_valid_q ? rdata : '0;
    assign row_open = (state_q == StActivating) || (state_q == StActive) ||
                      (state_q == StReading)    || (state_q == StWriting);
    assign open_row = open_row_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ddr_bank_ctrl.sv
// Scoreboard bench for ddr_bank_ctrl: read beats are queued with their expected cycle and
// value at issue time; a negedge monitor pops and compares whenever dq_valid is seen.
module tb_ddr_bank_ctrl;
    import ddr_pkg::*;

    localparam int CL  = 3;
    localparam int CWL = 2;
    localparam int BL  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    cmd_t       cmd;
    logic [7:0] row;
    logic [6:0] column;
    logic [3:0] dqin;
    logic [3:0] dqout;
    logic       dq_valid;
    logic       row_open;
    logic [7:0] open_row;
    logic       err;

    typedef struct {
        int data;
        int cyc;
    } beat_t;

    beat_t exp_q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    misses = 0;

    ddr_bank_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .row       (row),
        .column    (column),
        .dqin      (dqin),
        .dqout     (dqout),
        .dq_valid  (dq_valid),
        .row_open  (row_open),
        .open_row  (open_row),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every presented beat must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (dq_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    misses++;
                    $display("FAIL stray_beat: got dq_valid=1 dqout=%0d at cycle %0d, expected no beat",
                             dqout, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_cycle", cyc, b.cyc);
                    check("beat_data", int'(dqout), b.data);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                b = exp_q.pop_front();
                vectors++;
                misses++;
                $display("FAIL missing_beat: got no beat by cycle %0d, expected %0d at cycle %0d",
                         cyc, b.data, b.cyc);
            end else if (dqout != 4'd0) begin
                vectors++;
                misses++;
                $display("FAIL idle_dqout: got %0d with dq_valid=0, expected 0", dqout);
            end
        end
    end

    // Drive a command at a negedge, hold until accepted; returns at the negedge after acceptance.
    task automatic issue(input cmd_t c, input int r, input int col, output int t);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        row       = 8'(r);
        column    = 7'(col);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            vectors++;
            misses++;
            $display("FAIL cmd_timeout: got cmd_ready=0 for 50 cycles, expected 1");
        end
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = CmdNop;
    endtask

    task automatic wr_burst(input int col, input int d[8]);
        int t;
        issue(CmdWr, 0, col, t);
        for (int i = 0; i < BL; i++) begin
            while (cyc < t + CWL + i) @(negedge clk);
            dqin = 4'(d[i]);
        end
        check("wr_busy_last_beat", int'(cmd_ready), 0);
        @(negedge clk);
        check("wr_ready_after", int'(cmd_ready), 1);
        dqin = 4'd0;
    endtask

    task automatic rd_burst(input int col, input int d[8]);
        int t;
        beat_t b;
        issue(CmdRd, 0, col, t);
        for (int i = 0; i < BL; i++) begin
            b.data = d[i];
            b.cyc  = t + CL + i;
            exp_q.push_back(b);
        end
        while (cyc < t + CL + BL + 1) @(negedge clk);
        check("rd_ready_after", int'(cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int inc[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
        int wrp[8]  = '{6, 7, 8, 1, 2, 3, 4, 5};
        int ff[8]   = '{15, 15, 15, 15, 15, 15, 15, 15};
        beat_t b;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd = CmdNop; row = '0; column = '0; dqin = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_row_open", int'(row_open), 0);
        check("rst_dq_valid", int'(dq_valid), 0);
        check("rst_dqout", int'(dqout), 0);
        check("rst_err", int'(err), 0);
        check("rst_open_row", int'(open_row), 0);

        // Open row 1 and write 1..8 at column 0
        issue(CmdAct, 1, 0, t);
        check("act_busy", int'(cmd_ready), 0);
        check("act_row_open", int'(row_open), 1);
        check("act_open_row", int'(open_row), 1);
        @(negedge clk);
        check("act_ready", int'(cmd_ready), 1);
        wr_burst(0, inc);

        // Back-to-back read and a wrapped read
        rd_burst(0, inc);
        rd_burst(5, wrp);

        // PRE, then RD while closed is illegal
        issue(CmdPre, 0, 0, t);
        check("pre_row_open", int'(row_open), 0);
        issue(CmdRd, 0, 0, t);
        check("rd_closed_err", int'(err), 1);
        check("rd_closed_ready", int'(cmd_ready), 1);
        check("rd_closed_row_open", int'(row_open), 0);
        @(negedge clk);
        check("rd_closed_err_clear", int'(err), 0);

        // ACT while active is illegal and must not move the open row
        issue(CmdAct, 2, 0, t);
        issue(CmdAct, 3, 0, t);
        check("act_active_err", int'(err), 1);
        check("act_active_open_row", int'(open_row), 2);
        check("act_active_ready", int'(cmd_ready), 1);
        @(negedge clk);
        check("act_active_err_clear", int'(err), 0);

        // Row isolation: row 2 writes must not disturb row 1
        wr_burst(0, ff);
        issue(CmdPre, 0, 0, t);
        issue(CmdAct, 1, 0, t);
        rd_burst(0, inc);

        // Reset in the middle of a read burst
        issue(CmdRd, 0, 0, t);
        for (int i = 0; i < BL; i++) begin
            b.data = inc[i];
            b.cyc  = t + CL + i;
            exp_q.push_back(b);
        end
        while (cyc < t + CL + 2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_dq_valid", int'(dq_valid), 0);
        check("midrst_dqout", int'(dqout), 0);
        check("midrst_row_open", int'(row_open), 0);
        check("midrst_cmd_ready", int'(cmd_ready), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(CmdAct, 1, 0, t);
        rd_burst(0, inc);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/ddr_bank_ctrl.md
Name: ddr_bank_ctrl

Overview:
- Parametrised successor to the existing single-bank DRAM model, used in the DDR emulation path.
- Adds a command-driven bank FSM (ACT/RD/WR/PRE) with an open-row register.
- Adds programmable tRCD/tRP/CL/CWL timing counters and automatic BL-beat bursts with DDR-style sequential column wrap.
- The bank-group/rank layer instantiates one per bank and drives it through a valid/ready command port.

Parameters:
- DEVICE_WIDTH, 4: dq width in bits.
- ROWS, 256: rows per bank (emulation-sized).
- COLS, 128: columns per row.
- BL, 8: burst length; power of 2, <= COLS.
- tRCD, 2: ACT-to-RD/WR cycles, >= 1.
- tRP, 2: PRE-to-ACT cycles, >= 1.
- CL, 3: RD-accept to first data-beat cycles, >= 2.
- CWL, 2: WR-accept to first data-sample cycles, >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd  in  cmd_t(3)  NOP/ACT/RD/WR/PRE.
- row  in  $clog2(ROWS)  row address, sampled on ACT.
- column  in  $clog2(COLS)  start column, sampled on RD/WR.
- dqin  in  DEVICE_WIDTH  write data.
- dqout  out  DEVICE_WIDTH  read data; 0 when dq_valid is low.
- dq_valid  out  1  read beat valid.
- row_open  out  1  a row is open (ACTIVE/READ/WRITE).
- open_row  out  $clog2(ROWS)  currently open row.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async assert, sync release): state CLOSED; cmd_ready=1, dq_valid=0, dqout=0, row_open=0, open_row=0, err=0; all counters 0. Array contents are not reset.
- States: CLOSED, ACTIVATING, ACTIVE, READING, WRITING, PRECHARGING.
- cmd_ready is 1 only in CLOSED and ACTIVE. A command is accepted at cycle T when cmd_valid & cmd_ready.
- CLOSED + ACT at T: latch row into open_row, row_open=1 from T+1, go ACTIVATING. ACTIVE (cmd_ready=1) at T+tRCD.
- ACTIVE + RD at T, column c: go READING.
  - dq_valid=1 for cycles T+CL .. T+CL+BL-1.
  - Beat i = mem[open_row][{c[hi], (c[lo]+i) mod BL}], where lo = low $clog2(BL) bits (sequential wrap inside the aligned burst).
  - ACTIVE at T+CL+BL.
- ACTIVE + WR at T, column c: go WRITING.
  - dqin sampled at cycles T+CWL .. T+CWL+BL-1 and written to the same wrapped addresses.
  - ACTIVE at T+CWL+BL.
- ACTIVE + PRE at T: row_open=0 from T+1, go PRECHARGING. CLOSED at T+tRP.
- NOP is always legal and ignored.
- Illegal commands: RD/WR/PRE in CLOSED, or ACT in ACTIVE. Effects:
  - err=1 at T+1 for exactly one cycle.
  - State, open_row and array unchanged.
- cmd_valid while cmd_ready=0: not accepted, no err. The source must hold the command.
- Read-after-write to the same column in back-to-back bursts returns the newly written data.
- rst_n low mid-burst:
  - Outputs go to reset values immediately (async).
  - Writes already committed remain; remaining beats are dropped.
- Counter widths are sized from max(tRCD, tRP, CL+BL, CWL+BL). Column arithmetic wraps modulo BL only in the low bits; no carry into the high bits.

Decomposition:
- Package ddr_pkg holds:
  - cmd_t enum: NOP=0, ACT=1, RD=2, WR=3, PRE=4.
  - bank_state_t enum.
  - Helper function burst_col(base, beat, BL).
- Sub-module bank_array:
  - ROWS*COLS x DEVICE_WIDTH storage.
  - One synchronous write port and one read port with 1-cycle registered read.
  - The FSM issues the read address at cycle T+CL-1+i.

Test Plan (defaults):
1. Reset: hold rst_n=0 for 3 cycles, then release -> cmd_ready=1, row_open=0, dq_valid=0, dqout=0, err=0.
2. Open and write: ACT row=1 at T -> cmd_ready=0 at T+1, 1 at T+2, open_row=1. Then WR col=0 at T', with dqin=1..8 on T'+2..T'+9 -> cmd_ready=1 at T'+10.
3. Read back: RD col=0 at T -> dq_valid=1 on T+3..T+10, dqout=1,2,3,4,5,6,7,8; dq_valid=0 at T+11.
4. Wrap: RD col=5 on row 1 -> beats 6,7,8,1,2,3,4,5.
5. Illegal and row isolation:
   - PRE, then RD in CLOSED -> err pulses one cycle, state stays CLOSED.
   - ACT row=2, then ACT again -> err.
   - WR row 2 col 0 with 0xF, then PRE, ACT row=1, RD col=0 -> 1..8 intact.
6. Reset mid-read: rst_n=0 during beat 3 -> dq_valid=0 and row_open=0 immediately. After release, ACT row 1 + RD col 0 -> 1..8.
